// File: rtl/countdown_timer_core.sv
// countdown_timer_core: 8-bit seconds down-counter with a prescaled tick.
// It supports load, start, pause and resume controls. The count output feeds
// the seven-segment decode stage directly.
module countdown_timer_core #(
  parameter int unsigned TICK_DIV = 50000000,
  parameter int unsigned PRE_W    = 26
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic [7:0] load_value,
  input  logic       start,
  input  logic       pause,
  output logic [7:0] count,
  output logic       running,
  output logic       tick,
  output logic       done
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_RUN    = 2'd1,
    S_PAUSED = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);

  state_t           r_state;
  logic [PRE_W-1:0] r_pre;
  logic [7:0]       r_count;
  logic             r_running;
  logic             r_tick;
  logic             r_done;
  logic             w_pre_wrap;

  // Prescaler has reached its last cycle of the current second
  always_comb begin
    w_pre_wrap = (r_pre == PRE_LAST);
  end

  // Control FSM, prescaler and countdown with registered status outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_pre     <= '0;
      r_count   <= '0;
      r_running <= 1'b0;
      r_tick    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_tick <= 1'b0;
      if (load) begin
        r_state   <= S_IDLE;
        r_pre     <= '0;
        r_count   <= load_value;
        r_running <= 1'b0;
        r_done    <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (start && (r_count != 8'd0)) begin
              r_state   <= S_RUN;
              r_pre     <= '0;
              r_running <= 1'b1;
            end
          end
          S_RUN: begin
            if (pause) begin
              r_state   <= S_PAUSED;
              r_running <= 1'b0;
            end else if (w_pre_wrap) begin
              r_pre   <= '0;
              r_count <= r_count - 8'd1;
              r_tick  <= 1'b1;
              // Reaching zero leaves RUN on the same edge, so no wrap to 255
              if (r_count == 8'd1) begin
                r_state   <= S_DONE;
                r_running <= 1'b0;
                r_done    <= 1'b1;
              end
            end else begin
              r_pre <= r_pre + PRE_W'(1);
            end
          end
          S_PAUSED: begin
            // Prescaler is left untouched so sub-second progress survives
            if (start && !pause) begin
              r_state   <= S_RUN;
              r_running <= 1'b1;
            end
          end
          S_DONE: begin
            r_state <= S_DONE;
          end
          default: begin
            r_state   <= S_IDLE;
            r_running <= 1'b0;
            r_done    <= 1'b0;
          end
        endcase
      end
    end
  end

  assign count   = r_count;
  assign running = r_running;
  assign tick    = r_tick;
  assign done    = r_done;

endmodule

// File: tb/tb_countdown_timer_core.sv
// Testbench for countdown_timer_core: one instance with TICK_DIV=4 and one
// with TICK_DIV=1 receive the same stimulus. Both are compared every cycle
// against an elapsed-time reference model.
module tb_countdown_timer_core;

  typedef enum int {M_IDLE, M_RUN, M_PAUSED, M_DONE} mode_t;
  typedef struct {
    mode_t mode;
    int    cnt;
    int    elapsed;
    bit    tk;
  } mdl_t;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       load = 1'b0;
  logic [7:0] load_value = '0;
  logic       start = 1'b0;
  logic       pause = 1'b0;

  logic [7:0] a_count, b_count;
  logic       a_running, b_running, a_tick, b_tick, a_done, b_done;

  int   vectors = 0;
  int   miscompares = 0;
  mdl_t ma = '{M_IDLE, 0, 0, 1'b0};
  mdl_t mb = '{M_IDLE, 0, 0, 1'b0};

  always #5 clk = ~clk;

  countdown_timer_core #(.TICK_DIV(4), .PRE_W(3)) u_a (
    .clk(clk), .reset(reset), .load(load), .load_value(load_value),
    .start(start), .pause(pause), .count(a_count), .running(a_running),
    .tick(a_tick), .done(a_done)
  );

  countdown_timer_core #(.TICK_DIV(1), .PRE_W(1)) u_b (
    .clk(clk), .reset(reset), .load(load), .load_value(load_value),
    .start(start), .pause(pause), .count(b_count), .running(b_running),
    .tick(b_tick), .done(b_done)
  );

  // A second elapses after div uninterrupted RUN cycles; the count drops
  // by one at that moment, and at zero the timer is finished.
  function automatic mdl_t model(mdl_t m, int div, bit rs, bit ld,
                                 int lv, bit st, bit ps);
    mdl_t n = m;
    n.tk = 1'b0;
    if (rs) begin
      n = '{M_IDLE, 0, 0, 1'b0};
    end else if (ld) begin
      n.mode = M_IDLE; n.cnt = lv; n.elapsed = 0;
    end else begin
      case (m.mode)
        M_IDLE:   if (st && m.cnt > 0) begin n.mode = M_RUN; n.elapsed = 0; end
        M_RUN: begin
          if (ps) n.mode = M_PAUSED;
          else begin
            n.elapsed = m.elapsed + 1;
            if (n.elapsed == div) begin
              n.elapsed = 0;
              n.cnt = m.cnt - 1;
              n.tk = 1'b1;
              if (n.cnt == 0) n.mode = M_DONE;
            end
          end
        end
        M_PAUSED: if (st && !ps) n.mode = M_RUN;
        default:  n.mode = m.mode;
      endcase
    end
    return n;
  endfunction

  task automatic cmp(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step(input bit rs, input bit ld, input logic [7:0] lv,
                      input bit st, input bit ps);
    reset = rs; load = ld; load_value = lv; start = st; pause = ps;
    @(posedge clk);
    ma = model(ma, 4, rs, ld, int'(lv), st, ps);
    mb = model(mb, 1, rs, ld, int'(lv), st, ps);
    #1;
    cmp("a_count",   a_count,         8'(ma.cnt));
    cmp("a_running", 8'(a_running),   8'(ma.mode == M_RUN));
    cmp("a_tick",    8'(a_tick),      8'(ma.tk));
    cmp("a_done",    8'(a_done),      8'(ma.mode == M_DONE));
    cmp("b_count",   b_count,         8'(mb.cnt));
    cmp("b_running", 8'(b_running),   8'(mb.mode == M_RUN));
    cmp("b_tick",    8'(b_tick),      8'(mb.tk));
    cmp("b_done",    8'(b_done),      8'(mb.mode == M_DONE));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 8'd0, 0, 0);
  endtask

  // Hand-derived expectations for the TICK_DIV=4 instance
  task automatic lit(input string tag, input int c, input bit r, input bit d, input bit t);
    cmp({tag, "_count"},   a_count,       8'(c));
    cmp({tag, "_running"}, 8'(a_running), 8'(r));
    cmp({tag, "_done"},    8'(a_done),    8'(d));
    cmp({tag, "_tick"},    8'(a_tick),    8'(t));
  endtask

  initial begin
    // Reset state
    step(1, 0, 8'd0, 0, 0);
    step(1, 0, 8'd0, 0, 0);
    lit("reset", 0, 0, 0, 0);

    // Basic countdown 3 -> 0 at 4-cycle spacing
    step(0, 1, 8'd3, 0, 0);
    step(0, 0, 8'd0, 1, 0);
    lit("basic_start", 3, 1, 0, 0);
    for (int i = 0; i < 12; i++) begin
      step(0, 0, 8'd0, 0, 0);
      if (i == 3)  lit("basic_dec1", 2, 1, 0, 1);
      if (i == 4)  lit("basic_gap", 2, 1, 0, 0);
      if (i == 7)  lit("basic_dec2", 1, 1, 0, 1);
      if (i == 11) lit("basic_done", 0, 0, 1, 1);
    end
    idle(1);
    lit("basic_after", 0, 0, 1, 0);

    // DONE ignores start and pause; load leaves it
    step(0, 0, 8'd0, 1, 0);
    step(0, 0, 8'd0, 0, 1);
    lit("done_hold", 0, 0, 1, 0);
    step(0, 1, 8'd2, 0, 0);
    lit("done_load", 2, 0, 0, 0);

    // Pause and resume keep the partial second
    step(0, 1, 8'd10, 0, 0);
    step(0, 0, 8'd0, 1, 0);
    idle(6);
    lit("pr_before", 9, 1, 0, 0);
    for (int i = 0; i < 10; i++) step(0, 0, 8'd0, 0, 1);
    lit("pr_paused", 9, 0, 0, 0);
    step(0, 0, 8'd0, 1, 0);
    lit("pr_resume", 9, 1, 0, 0);
    idle(1);
    lit("pr_run1", 9, 1, 0, 0);
    idle(1);
    lit("pr_dec", 8, 1, 0, 1);

    // Load beats pause and start in RUN; start+pause holds PAUSED
    step(0, 1, 8'd5, 0, 0);
    step(0, 0, 8'd0, 1, 0);
    idle(2);
    step(0, 1, 8'd7, 1, 1);
    lit("prio_load", 7, 0, 0, 0);
    step(0, 0, 8'd0, 1, 0);
    step(0, 0, 8'd0, 0, 1);
    step(0, 0, 8'd0, 1, 1);
    lit("prio_sp", 7, 0, 0, 0);
    idle(5);
    lit("prio_held", 7, 0, 0, 0);

    // Start with count 0 is ignored; 255 counts down without wrap
    step(1, 0, 8'd0, 0, 0);
    step(0, 0, 8'd0, 1, 0);
    lit("empty_start", 0, 0, 0, 0);
    step(0, 1, 8'd255, 0, 0);
    step(0, 0, 8'd0, 1, 0);
    idle(4);
    lit("full_dec", 254, 1, 0, 1);

    // Reset mid-run with prescaler at 2
    step(0, 1, 8'd50, 0, 0);
    step(0, 0, 8'd0, 1, 0);
    idle(2);
    step(1, 0, 8'd0, 0, 0);
    lit("mid_reset", 0, 0, 0, 0);
    idle(2);
    lit("mid_reset_hold", 0, 0, 0, 0);

    // Randomised control traffic
    for (int i = 0; i < 3000; i++) begin
      bit         rs, ld, st, ps;
      logic [7:0] lv;
      rs = ($urandom_range(0, 199) == 0);
      ld = ($urandom_range(0, 39) == 0);
      st = ($urandom_range(0, 3) == 0);
      ps = ($urandom_range(0, 9) == 0);
      lv = ($urandom_range(0, 1) == 0) ? 8'($urandom_range(0, 12)) : 8'($urandom);
      step(rs, ld, lv, st, ps);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
